// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, chase, bounce and PWM fade.
// A debounced button press advances the display mode.
module led_pattern_gen #(
    parameter int WIDTH         = 8,
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_BITS = 16,
    parameter int PWM_BITS      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        MODE_BINARY = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FADE   = 2'd3
    } mode_e;

    localparam logic [LOG2DELAY-1:0]     PRE_ONE  = 1;
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE   = 1;
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX   = '1;
    localparam logic [WIDTH-1:0]         CNT_ONE  = 1;
    localparam logic [WIDTH-1:0]         POS_INIT = 1;
    localparam logic [PWM_BITS-1:0]      LVL_ONE  = 1;
    localparam logic [PWM_BITS-1:0]      LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0]      LVL_PEN  = LVL_MAX - LVL_ONE;

    mode_e                    mode_q, mode_d;
    logic [LOG2DELAY-1:0]     pre_q, pre_d;
    logic                     sync1_q, sync2_q;
    logic                     db_level_q, db_level_d;
    logic                     db_prev_q;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
    logic [WIDTH-1:0]         count_q, count_d;
    logic [WIDTH-1:0]         pos_q, pos_d;
    logic                     dir_down_q, dir_down_d;
    logic [PWM_BITS-1:0]      lvl_q, lvl_d;
    logic                     fade_down_q, fade_down_d;
    logic [PWM_BITS-1:0]      pwm_q, pwm_d;
    logic [WIDTH-1:0]         led_q, led_d;
    logic                     tick;
    logic                     press;

    assign pre_d = pre_q + PRE_ONE;
    assign pwm_d = pwm_q + LVL_ONE;
    assign tick  = &pre_q;
    assign press = db_level_q & ~db_prev_q;

    // Counter only runs while the synchronised input disagrees with the
    // accepted level, so any bounce back restarts the qualification window.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_MAX) begin
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    always_comb begin
        mode_d      = mode_q;
        count_d     = count_q;
        pos_d       = pos_q;
        dir_down_d  = dir_down_q;
        lvl_d       = lvl_q;
        fade_down_d = fade_down_q;
        if (press) begin
            mode_d      = mode_e'(mode_q + 2'd1);
            count_d     = '0;
            pos_d       = POS_INIT;
            dir_down_d  = 1'b0;
            lvl_d       = '0;
            fade_down_d = 1'b0;
        end else if (tick) begin
            unique case (mode_q)
                MODE_BINARY: begin
                    count_d = count_q + CNT_ONE;
                end
                MODE_CHASE: begin
                    pos_d = {pos_q[WIDTH-2:0], pos_q[WIDTH-1]};
                end
                MODE_BOUNCE: begin
                    if (!dir_down_q) begin
                        pos_d = pos_q << 1;
                        if (pos_q[WIDTH-2]) dir_down_d = 1'b1;
                    end else begin
                        pos_d = pos_q >> 1;
                        if (pos_q[1]) dir_down_d = 1'b0;
                    end
                end
                MODE_FADE: begin
                    if (!fade_down_q) begin
                        lvl_d = lvl_q + LVL_ONE;
                        if (lvl_q == LVL_PEN) fade_down_d = 1'b1;
                    end else begin
                        lvl_d = lvl_q - LVL_ONE;
                        if (lvl_q == LVL_ONE) fade_down_d = 1'b0;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_comb begin
        led_d = '0;
        unique case (mode_q)
            MODE_BINARY: led_d = count_q;
            MODE_CHASE:  led_d = pos_q;
            MODE_BOUNCE: led_d = pos_q;
            MODE_FADE:   led_d = {WIDTH{pwm_q < lvl_q}};
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_BINARY;
            pre_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_level_q  <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            count_q     <= '0;
            pos_q       <= POS_INIT;
            dir_down_q  <= 1'b0;
            lvl_q       <= '0;
            fade_down_q <= 1'b0;
            pwm_q       <= '0;
            led_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            pre_q       <= pre_d;
            sync1_q     <= sel;
            sync2_q     <= sync1_q;
            db_level_q  <= db_level_d;
            db_prev_q   <= db_level_q;
            db_cnt_q    <= db_cnt_d;
            count_q     <= count_d;
            pos_q       <= pos_d;
            dir_down_q  <= dir_down_d;
            lvl_q       <= lvl_d;
            fade_down_q <= fade_down_d;
            pwm_q       <= pwm_d;
            led_q       <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with small parameters
// (WIDTH=4, LOG2DELAY=3, DEBOUNCE_BITS=2, PWM_BITS=2).
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [3:0] led;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt = 0;

    led_pattern_gen #(
        .WIDTH(4),
        .LOG2DELAY(3),
        .DEBOUNCE_BITS(2),
        .PWM_BITS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .led (led),
        .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since the last edge that sampled rst=1.
    always @(posedge clk) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, obs, exp, ecnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_edge(input int n);
        while (ecnt < n) step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Starts at an edge with ecnt%8==ph; mode changes 7 edges later.
    task automatic do_press(input int ph, input int exp_mode);
        int prev;
        prev = (exp_mode + 3) % 4;
        while ((ecnt % 8) != ph) step(1);
        sel = 1'b1;
        step(6);
        check_eq("mode_before_press", int'(mode), prev);
        sel = 1'b0;
        step(1);
        check_eq("mode_after_press", int'(mode), exp_mode);
    endtask

    task automatic run_binary();
        check_eq("bin_e0_led", int'(led), 0);
        check_eq("bin_e0_mode", int'(mode), 0);
        goto_edge(8);
        check_eq("bin_e8", int'(led), 0);
        goto_edge(9);
        check_eq("bin_e9", int'(led), 1);
        goto_edge(17);
        check_eq("bin_e17", int'(led), 2);
        goto_edge(121);
        check_eq("bin_e121", int'(led), 15);
        goto_edge(129);
        check_eq("bin_wrap", int'(led), 0);
        check_eq("bin_mode", int'(mode), 0);
    endtask

    logic [3:0] chase_seq  [5];
    logic [3:0] bounce_seq [8];
    int         fade_lvl   [8];

    initial begin
        int c;
        int ones;
        int zeros;
        chase_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bounce_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                       4'b0100, 4'b0010, 4'b0001, 4'b0010};
        fade_lvl   = '{1, 2, 3, 2, 1, 0, 1, 2};
        rst = 1'b1;
        sel = 1'b0;
        do_reset();

        run_binary();

        do_press(0, 1);
        step(1);
        check_eq("chase_0", int'(led), int'(chase_seq[0]));
        for (int i = 1; i < 5; i++) begin
            step(8);
            check_eq("chase_n", int'(led), int'(chase_seq[i]));
        end
        check_eq("held_one_press", int'(mode), 1);

        while ((ecnt % 8) != 0) step(1);
        sel = 1'b1;
        step(3);
        sel = 1'b0;
        step(20);
        check_eq("glitch_mode", int'(mode), 1);

        do_press(0, 2);
        step(1);
        check_eq("bounce_0", int'(led), int'(bounce_seq[0]));
        for (int i = 1; i < 8; i++) begin
            step(8);
            check_eq("bounce_n", int'(led), int'(bounce_seq[i]));
        end

        do_press(0, 3);
        c = ecnt - 7;
        step(1);
        check_eq("fade_lvl0", int'(led), 0);
        for (int k = 1; k <= 8; k++) begin
            goto_edge(c + 8 * k);
            ones  = 0;
            zeros = 0;
            repeat (4) begin
                step(1);
                if (led == 4'b1111) ones++;
                if (led == 4'b0000) zeros++;
            end
            check_eq("fade_duty", ones * 16 + zeros,
                     fade_lvl[k-1] * 16 + (4 - fade_lvl[k-1]));
        end

        // Press lands on a tick edge: the tick must be dropped.
        do_press(1, 0);
        step(1);
        check_eq("wrap_cnt0", int'(led), 0);
        step(8);
        check_eq("wrap_cnt1", int'(led), 1);

        do_press(0, 1);
        step(10);
        do_press(0, 2);
        step(20);
        check_eq("mid_bounce_mode", int'(mode), 2);
        do_reset();
        run_binary();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
